// File: rtl/sc_chain_test_pkg.sv
// Shared definitions for the standard-cell shift-chain test controller:
// FSM state codes, pattern mode codes and the LFSR step function.
package sc_chain_test_pkg;

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Pattern selections
  localparam logic [1:0] MODE_ZERO = 2'd0;
  localparam logic [1:0] MODE_ONE  = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  // 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right:
  // the taps land on bits 0, 2, 3 and 5 of the current state.
  localparam int                LFSR_W        = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/sc_pattern_gen.sv
// Serial pattern generator. Two copies run in lock-step with the same
// seed and mode: one feeds the chain, the other supplies expected bits.
module sc_pattern_gen
  import sc_chain_test_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_adv,
  input  logic [1:0] i_mode,
  output logic       o_bit
);

  logic [1:0]        r_mode;
  logic [LFSR_W-1:0] r_lfsr;
  logic              r_t0;

  // Load restarts the sequence at t=0; advance steps it by one bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= MODE_ZERO;
      r_lfsr <= LFSR_SEED;
      r_t0   <= 1'b0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_lfsr <= LFSR_SEED;
      r_t0   <= 1'b0;
    end else if (i_adv) begin
      r_lfsr <= lfsr_step(r_lfsr);
      r_t0   <= ~r_t0;
    end
  end

  // Current output bit for the latched mode.
  always_comb begin
    case (r_mode)
      MODE_ZERO: o_bit = 1'b0;
      MODE_ONE:  o_bit = 1'b1;
      MODE_ALT:  o_bit = r_t0;
      default:   o_bit = r_lfsr[0];
    endcase
  end

endmodule

// File: rtl/sc_chain_test_ctrl.sv
// Shift-chain test controller: pushes NBITS pattern bits through an
// external CHAIN_LEN-deep flop chain and checks what comes out the tail.
// Chain outputs are registered so the external clock gate sees clean
// edges; cycle index c of the run is presented from edge c+1 onward.
module sc_chain_test_ctrl
  import sc_chain_test_pkg::*;
#(
  parameter int                CHAIN_LEN = 64,
  parameter int                CNT_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_nbits,
  output logic             o_chain_d,
  output logic             o_chain_en,
  input  logic             i_chain_q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_first_err
);

  // Counter must reach NBITS+CHAIN_LEN without wrapping for any NBITS.
  localparam int             LEN_W = $clog2(CHAIN_LEN + 1);
  localparam int             C_W   = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam logic [C_W-1:0] C_LEN = C_W'(CHAIN_LEN);

  state_t           r_state;
  logic [C_W-1:0]   r_cnt;
  logic [CNT_W-1:0] r_nbits;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_chain_en;
  logic             r_chain_d;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_first_err;

  logic             w_accept;
  logic             w_in_shift;
  logic             w_last;
  logic             w_tx_adv;
  logic             w_cmp;
  logic             w_mis;
  logic             w_tx_bit;
  logic             w_exp_bit;
  logic [C_W-1:0]   w_total;
  logic [CNT_W-1:0] w_idx;
  logic [CNT_W-1:0] w_err_next;
  logic [CNT_W-1:0] w_first_next;

  // r_cnt holds the cycle index being set up for the chain; the bit now
  // on CHAIN_Q therefore belongs to cycle r_cnt-1, i.e. pattern index
  // r_cnt-1-CHAIN_LEN.
  assign w_accept   = (r_state != ST_SHIFT) && i_start;
  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_total    = C_W'(r_nbits) + C_LEN;
  assign w_last     = w_in_shift && ((r_nbits == '0) || (r_cnt == w_total));
  assign w_tx_adv   = w_in_shift && (r_cnt < C_W'(r_nbits));
  assign w_cmp      = w_in_shift && (r_cnt > C_LEN) && (r_cnt <= w_total);
  assign w_idx      = CNT_W'(r_cnt - C_LEN - C_W'(1));
  assign w_mis      = w_cmp && (i_chain_q != w_exp_bit);

  assign w_err_next   = (w_mis && (r_err_cnt != '1)) ? r_err_cnt + 1'b1 : r_err_cnt;
  assign w_first_next = (w_mis && (r_first_err == '1)) ? w_idx : r_first_err;

  sc_pattern_gen #(.LFSR_SEED(LFSR_SEED)) u_tx_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_adv   (w_tx_adv),
    .i_mode  (i_mode),
    .o_bit   (w_tx_bit)
  );

  sc_pattern_gen #(.LFSR_SEED(LFSR_SEED)) u_exp_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_adv   (w_cmp),
    .i_mode  (i_mode),
    .o_bit   (w_exp_bit)
  );

  // FSM, cycle counter, chain drive and result capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_nbits     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_chain_en  <= 1'b0;
      r_chain_d   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '1;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_err_cnt   <= w_err_next;
          r_first_err <= w_first_next;
          if (w_last) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_pass     <= (w_err_next == '0);
            r_chain_en <= 1'b0;
            r_chain_d  <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_chain_en <= 1'b1;
            r_chain_d  <= w_tx_adv & w_tx_bit;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state     <= ST_SHIFT;
            r_nbits     <= i_nbits;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_chain_d   = r_chain_d;
  assign o_chain_en  = r_chain_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_err = r_first_err;

endmodule

// File: tb/tb_sc_chain_test_ctrl.sv
// Bench for sc_chain_test_ctrl: a gated shift-register chain with fault
// injection, a run-level reference model and a per-cycle output checker.
`timescale 1ns/1ps
module tb_sc_chain_test_ctrl;

  localparam int L   = 64;
  localparam int CW  = 16;
  localparam int L4  = 8;
  localparam int CW4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] nbits;
  logic          chain_d, chain_en, chain_q, busy, done, pass;
  logic [CW-1:0] err_cnt, first_err;

  logic           start4;
  logic [1:0]     mode4;
  logic [CW4-1:0] nbits4;
  logic           q4;
  logic           chain_d4, chain_en4, busy4, done4, pass4;
  logic [CW4-1:0] err4, first4;

  sc_chain_test_ctrl #(.CHAIN_LEN(L), .CNT_W(CW), .LFSR_SEED(16'hACE1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_nbits(nbits),
    .o_chain_d(chain_d), .o_chain_en(chain_en), .i_chain_q(chain_q),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_cnt(err_cnt), .o_first_err(first_err)
  );

  sc_chain_test_ctrl #(.CHAIN_LEN(L4), .CNT_W(CW4), .LFSR_SEED(16'hACE1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_mode(mode4), .i_nbits(nbits4),
    .o_chain_d(chain_d4), .o_chain_en(chain_en4), .i_chain_q(q4),
    .o_busy(busy4), .o_done(done4), .o_pass(pass4),
    .o_err_cnt(err4), .o_first_err(first4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- external chain with fault injection ----------------
  // fault: 0 none, 1 tail stuck-at-0, 2 tail stuck-at-1, 3 flip listed indices
  logic sr [L];
  int   tag [L];
  int   push_cnt = 0;
  int   fault = 0;
  bit   fmask [4096];

  initial begin
    for (int k = 0; k < L; k++) begin
      sr[k]  = 1'($urandom);
      tag[k] = -1;
    end
  end

  always @(posedge clk) begin
    if (chain_en) begin
      sr[0]  <= chain_d;
      tag[0] <= push_cnt;
      for (int k = 1; k < L; k++) begin
        sr[k]  <= sr[k-1];
        tag[k] <= tag[k-1];
      end
      push_cnt <= push_cnt + 1;
    end else begin
      push_cnt <= 0;
    end
  end

  always_comb begin
    chain_q = sr[L-1];
    if (fault == 3 && tag[L-1] >= 0 && tag[L-1] < 4096)
      chain_q = sr[L-1] ^ fmask[tag[L-1]];
    if (fault == 1) chain_q = 1'b0;
    if (fault == 2) chain_q = 1'b1;
  end

  // ---------------- run-level reference model ----------------
  int m_state = 0;  // 0 idle, 1 running, 2 finished
  int m_j = 0;      // clock edges since the accepting edge
  int m_n = 0;
  int m_done_at = 1;
  int m_err = 0;
  int m_first = 32'hFFFF;
  bit m_pass = 1'b0;
  bit m_pat [4096];

  task automatic model_accept(input int md, input int n);
    logic [15:0] s;
    bit r;
    s = 16'hACE1;
    m_n = n;
    m_done_at = (n == 0) ? 1 : n + L + 1;
    for (int i = 0; i < n; i++) begin
      case (md)
        0: m_pat[i] = 1'b0;
        1: m_pat[i] = 1'b1;
        2: m_pat[i] = bit'(i % 2);
        default: begin
          m_pat[i] = s[0];
          s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end
      endcase
    end
    m_err = 0;
    m_first = 32'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (fault == 1)      r = 1'b0;
      else if (fault == 2) r = 1'b1;
      else if (fault == 3) r = m_pat[i] ^ fmask[i];
      else                 r = m_pat[i];
      if (r != m_pat[i]) begin
        if (m_err < 32'hFFFF) m_err++;
        if (m_first == 32'hFFFF) m_first = i;
      end
    end
    m_pass = (m_err == 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_state = 0;
      end else if (m_state != 1) begin
        if (start) begin
          model_accept(int'(mode), int'(nbits));
          m_state = 1;
          m_j = 0;
        end
      end else begin
        m_j++;
        if (m_j >= m_done_at) m_state = 2;
      end
    end
  end

  // ---------------- per-cycle output checker ----------------
  initial begin
    bit e_en, e_d;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || m_state == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_pass", pass, 0);
        chk("idle_en", chain_en, 0);
        chk("idle_d", chain_d, 0);
        chk("idle_err", err_cnt, 0);
        chk("idle_first", first_err, 32'hFFFF);
      end else if (m_state == 1) begin
        e_en = (m_n > 0) && (m_j >= 1) && (m_j <= m_n + L);
        e_d  = (e_en && (m_j - 1) < m_n) ? m_pat[m_j-1] : 1'b0;
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_pass", pass, 0);
        chk("run_en", chain_en, e_en);
        chk("run_d", chain_d, e_d);
        if (m_j == 0) begin
          chk("run_err_clr", err_cnt, 0);
          chk("run_first_clr", first_err, 32'hFFFF);
        end
      end else begin
        chk("fin_busy", busy, 0);
        chk("fin_done", done, 1);
        chk("fin_en", chain_en, 0);
        chk("fin_d", chain_d, 0);
        chk("fin_err", err_cnt, m_err);
        chk("fin_first", first_err, m_first);
        chk("fin_pass", pass, m_pass);
      end
    end
  end

  // ---------------- stimulus ----------------
  // act_kind: 0 none, 1 pulse START at cycle act_at, 2 pull reset at act_at
  task automatic do_run(input int md, input int n, input int fk,
                        input int act_kind, input int act_at, output int lat);
    int k;
    @(negedge clk);
    mode = 2'(md); nbits = CW'(n); fault = fk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    lat = -1;
    while (k < n + L + 20) begin
      @(posedge clk);
      #1;
      k++;
      if (done) begin
        lat = k;
        break;
      end
      if (act_kind == 1 && k == act_at) begin
        @(negedge clk);
        start = 1'b1; mode = ~mode; nbits = nbits + 5;
        @(negedge clk);
        start = 1'b0;
        k++;
      end else if (act_kind == 2 && k == act_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", chain_en, 0);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (lat < 0) chk("run_timeout", 0, 1);
  endtask

  task automatic run4(input int md, input int n, input bit q);
    int k;
    @(negedge clk);
    mode4 = 2'(md); nbits4 = CW4'(n); q4 = q; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (!done4 && k < n + L4 + 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("dut4_done", done4, 1);
    chk("dut4_lat", k, (n == 0) ? 1 : n + L4 + 1);
  endtask

  initial begin
    int lat, n, md, fk, nf;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; nbits = '0;
    start4 = 1'b0; mode4 = 2'd0; nbits4 = '0; q4 = 1'b0;
    for (int i = 0; i < 4096; i++) fmask[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_first_lit", first_err, 32'hFFFF);
    chk("rst_en_lit", chain_en, 0);
    rst_n = 1'b1;

    // LFSR run on a clean chain
    do_run(3, 1000, 0, 0, 0, lat);
    chk("lfsr_latency", lat, 1065);
    chk("lfsr_err", err_cnt, 0);
    chk("lfsr_pass", pass, 1);
    chk("lfsr_model_b0", m_pat[0], 1);
    chk("lfsr_model_b1", m_pat[1], 0);
    chk("lfsr_model_b2", m_pat[2], 0);

    // tail stuck-at-1, all-zero pattern
    do_run(0, 10, 2, 0, 0, lat);
    chk("sa1_err", err_cnt, 10);
    chk("sa1_first", first_err, 0);
    chk("sa1_pass", pass, 0);
    chk("sa1_model_err", m_err, 10);

    // single flipped bit at index 37, alternating pattern
    fmask[37] = 1'b1;
    do_run(2, 100, 3, 0, 0, lat);
    fmask[37] = 1'b0;
    chk("flip_err", err_cnt, 1);
    chk("flip_first", first_err, 37);
    chk("flip_model_first", m_first, 37);

    // zero-length run, then START pulsed mid-shift
    do_run(1, 0, 0, 0, 0, lat);
    chk("zero_latency", lat, 1);
    chk("zero_pass", pass, 1);
    do_run(2, 20, 0, 1, 10, lat);
    chk("nostart_latency", lat, 85);

    // reset in the middle of a run, then rerun over a garbage chain
    do_run(3, 300, 0, 2, 100, lat);
    do_run(1, 50, 0, 0, 0, lat);
    chk("rerun_pass", pass, 1);
    chk("rerun_err", err_cnt, 0);

    // randomized runs
    for (int r = 0; r < 14; r++) begin
      md = $urandom_range(0, 3);
      n  = $urandom_range(0, 150);
      fk = $urandom_range(0, 3);
      if (fk == 3 && n > 0) begin
        nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++) fmask[$urandom_range(0, n - 1)] = 1'b1;
      end
      do_run(md, n, fk, ($urandom_range(0, 3) == 0) ? 1 : 0, 5, lat);
      for (int i = 0; i < 4096; i++) fmask[i] = 1'b0;
    end
    fault = 0;

    // narrow-counter instance: 4-bit counts, 8-deep chain tied stuck
    run4(1, 12, 1'b0);
    chk("n4_err12", err4, 12);
    chk("n4_first12", first4, 0);
    chk("n4_pass12", pass4, 0);
    run4(1, 15, 1'b0);
    chk("n4_err15", err4, 15);
    chk("n4_first15", first4, 0);
    run4(0, 15, 1'b0);
    chk("n4_clean_err", err4, 0);
    chk("n4_clean_pass", pass4, 1);
    chk("n4_clean_first", first4, 15);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
